uart_tx_buffer: RTL and testbench

- Buffered transmit front-end. Sits between a byte producer (CPU bus or packet logic) and the existing uart_tx.
- Accepts bursts of bytes into a synchronous FIFO.
- Drains the FIFO into uart_tx one frame at a time. Drives uart_tx's tx_en/data_in and obeys its tx_busy.
- Is the writer side of the uart_tx handshake, so producers never have to poll tx_busy themselves.

---
 rtl/uart_tx_buffer.sv | 138 +++++++++++++
 tb/tb_uart_tx_buffer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffer.sv
// Buffered transmit front-end: a synchronous FIFO drained one frame at a time
// into uart_tx through its tx_en / tx_busy handshake.
module uart_tx_buffer #(
  parameter int DATABITS = 8,
  parameter int DEPTH    = 16,
  parameter int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [DATABITS-1:0] wr_data,
  input  logic                flush,
  output logic                full,
  output logic                empty,
  output logic [CNT_W-1:0]    count,
  output logic                overflow,
  input  logic                tx_busy,
  output logic                tx_en,
  output logic [DATABITS-1:0] tx_data_out,
  output logic                frame_done
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_BUSY = 2'd2;

  logic [DATABITS-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_r;
  logic [PTR_W-1:0]    rd_ptr_r;
  logic [CNT_W-1:0]    count_r;
  logic [CNT_W-1:0]    count_next_s;
  logic                full_r;
  logic                empty_r;
  logic                overflow_r;
  logic                tx_en_r;
  logic                frame_done_r;
  logic [DATABITS-1:0] tx_data_r;
  logic [1:0]          state_r;
  logic [1:0]          state_next_s;
  logic                wr_accept_s;
  logic                wr_drop_s;
  logic                pop_s;
  logic                done_s;

  // Write/pop qualification; flush silently swallows both.
  always_comb begin
    wr_accept_s = wr_en & ~full_r & ~flush;
    wr_drop_s   = wr_en &  full_r & ~flush;
    pop_s       = (state_r == ST_IDLE) & ~empty_r & ~flush;
    done_s      = (state_r == ST_BUSY) & ~tx_busy;
  end

  // Next occupancy, net of a same-cycle write and pop.
  always_comb begin
    count_next_s = count_r;
    if (flush) begin
      count_next_s = {CNT_W{1'b0}};
    end else if (wr_accept_s && !pop_s) begin
      count_next_s = count_r + CNT_W'(1);
    end else if (!wr_accept_s && pop_s) begin
      count_next_s = count_r - CNT_W'(1);
    end else begin
      count_next_s = count_r;
    end
  end

  // Handshake sequencer: a stale tx_busy in REQ is taken as the acknowledge.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (pop_s) state_next_s = ST_REQ;
        else       state_next_s = ST_IDLE;
      end
      ST_REQ: begin
        if (tx_busy) state_next_s = ST_BUSY;
        else         state_next_s = ST_REQ;
      end
      ST_BUSY: begin
        if (!tx_busy) state_next_s = ST_IDLE;
        else          state_next_s = ST_BUSY;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // FIFO storage; contents need no reset since the pointers gate every read.
  always_ff @(posedge clk) begin
    if (wr_accept_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers, occupancy flags, FSM and all registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_r     <= {PTR_W{1'b0}};
      rd_ptr_r     <= {PTR_W{1'b0}};
      count_r      <= {CNT_W{1'b0}};
      full_r       <= 1'b0;
      empty_r      <= 1'b1;
      overflow_r   <= 1'b0;
      state_r      <= ST_IDLE;
      tx_en_r      <= 1'b0;
      tx_data_r    <= {DATABITS{1'b0}};
      frame_done_r <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr_r <= {PTR_W{1'b0}};
        rd_ptr_r <= {PTR_W{1'b0}};
      end else begin
        if (wr_accept_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
        if (pop_s)       rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        tx_data_r <= mem_r[rd_ptr_r];
      end
      count_r      <= count_next_s;
      full_r       <= (count_next_s == CNT_W'(DEPTH));
      empty_r      <= (count_next_s == {CNT_W{1'b0}});
      overflow_r   <= wr_drop_s;
      state_r      <= state_next_s;
      tx_en_r      <= (state_next_s == ST_REQ);
      frame_done_r <= done_s;
    end
  end

  assign full        = full_r;
  assign empty       = empty_r;
  assign count       = count_r;
  assign overflow    = overflow_r;
  assign tx_en       = tx_en_r;
  assign tx_data_out = tx_data_r;
  assign frame_done  = frame_done_r;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Randomized self-checking bench for uart_tx_buffer with a queue-based
// reference model and a simple behavioural uart_tx stand-in.
module tb_uart_tx_buffer;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       flush;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       tx_busy = 1'b0;
  logic       tx_en;
  logic [7:0] tx_data_out;
  logic       frame_done;

  uart_tx_buffer dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .flush       (flush),
    .full        (full),
    .empty       (empty),
    .count       (count),
    .overflow    (overflow),
    .tx_busy     (tx_busy),
    .tx_en       (tx_en),
    .tx_data_out (tx_data_out),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a byte queue plus "frame in flight" / "busy seen" flags.
  logic [7:0] m_q[$];
  bit         m_cur  = 1'b0;
  bit         m_seen = 1'b0;
  logic [7:0] m_data = 8'h00;
  bit         m_ovf  = 1'b0;
  bit         m_done = 1'b0;
  bit         chk_en = 1'b0;
  int         done_cnt = 0;
  int         ovf_cnt  = 0;

  always @(posedge clk) begin : model
    bit pop_b;
    bit acc_b;
    if (!reset) begin
      m_q.delete();
      m_cur  = 1'b0;
      m_seen = 1'b0;
      m_data = 8'h00;
      m_ovf  = 1'b0;
      m_done = 1'b0;
      chk_en = 1'b1;
    end else begin
      acc_b  = wr_en && !flush && (m_q.size() < DEPTH);
      m_ovf  = wr_en && !flush && (m_q.size() == DEPTH);
      pop_b  = !m_cur && (m_q.size() > 0) && !flush;
      m_done = 1'b0;
      if (m_cur) begin
        if (!m_seen) begin
          if (tx_busy) m_seen = 1'b1;
        end else if (!tx_busy) begin
          m_done = 1'b1;
          m_cur  = 1'b0;
          m_seen = 1'b0;
        end
      end
      if (flush) begin
        m_q.delete();
      end else begin
        if (pop_b) begin
          m_data = m_q.pop_front();
          m_cur  = 1'b1;
          m_seen = 1'b0;
        end
        if (acc_b) m_q.push_back(wr_data);
      end
    end
    #1;
    if (chk_en) begin
      check_value("count",      count,       m_q.size());
      check_value("empty",      empty,       m_q.size() == 0);
      check_value("full",       full,        m_q.size() == DEPTH);
      check_value("tx_en",      tx_en,       m_cur && !m_seen);
      check_value("tx_data",    tx_data_out, m_data);
      check_value("overflow",   overflow,    m_ovf);
      check_value("frame_done", frame_done,  m_done);
      if (frame_done) done_cnt++;
      if (overflow)   ovf_cnt++;
    end
  end

  // uart_tx stand-in: busy rises raise_dly cycles after tx_en, then holds.
  bit         force_busy = 1'b0;
  bit         hold_fixed = 1'b0;
  int         raise_dly  = 3;
  int         u_phase    = 0;
  int         u_cnt      = 0;
  logic [7:0] rx_q[$];

  always @(posedge clk) begin : uart_model
    #3;
    if (!reset) begin
      u_phase = 0;
      tx_busy = 1'b0;
    end else if (force_busy) begin
      u_phase = 0;
      tx_busy = 1'b1;
    end else begin
      case (u_phase)
        0: begin
          tx_busy = 1'b0;
          if (tx_en) begin
            u_phase = 1;
            u_cnt   = raise_dly - 1;
          end
        end
        1: begin
          if (u_cnt <= 0) begin
            tx_busy = 1'b1;
            rx_q.push_back(tx_data_out);
            u_phase = 2;
            u_cnt   = hold_fixed ? 99 : int'($urandom_range(1, 5));
          end else u_cnt--;
        end
        default: begin
          if (u_cnt <= 0) begin
            tx_busy = 1'b0;
            u_phase = 0;
          end else u_cnt--;
        end
      endcase
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] d);
    wr_en = 1'b1;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (m_q.size() == 0 && !m_cur) break;
      tick();
    end
    check_value(tag, (m_q.size() == 0 && !m_cur), 1);
    tick();
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int base_done;
    int base_ovf;
    int base_rx;
    int ok;
    logic [7:0] sent[$];
    logic [7:0] d;

    reset = 1'b0; wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0;
    tick(); tick();
    check_value("rst_count", count, 0);
    check_value("rst_empty", empty, 1);
    reset = 1'b1;
    tick();

    // 1: single byte with a long frame
    hold_fixed = 1'b1;
    base_done = done_cnt;
    wr(8'hA5);
    check_value("t1_count", count, 1);
    wait_idle("t1_drain", 400);
    check_value("t1_frames", done_cnt - base_done, 1);
    hold_fixed = 1'b0;

    // 2: back-to-back burst of 16
    base_done = done_cnt;
    base_rx   = rx_q.size();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(i);
      tick();
    end
    wr_en = 1'b0;
    wait_idle("t2_drain", 3000);
    check_value("t2_frames", done_cnt - base_done, 16);
    check_value("t2_rx_len", rx_q.size() - base_rx, 16);
    for (int i = 0; i < 16 && base_rx + i < rx_q.size(); i++)
      check_value("t2_rx_order", rx_q[base_rx + i], 8'(i));

    // 3: overflow under a stuck busy line
    force_busy = 1'b1;
    base_ovf = ovf_cnt;
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'b1;
      wr_data = 8'($urandom);
      tick();
    end
    wr_en = 1'b0;
    tick();
    check_value("t3_full", full, 1);
    check_value("t3_ovf_pulses", ovf_cnt - base_ovf, 3);
    force_busy = 1'b0;
    wait_idle("t3_drain", 3000);

    // 4: interleaved traffic across two pointer wraps
    sent.delete();
    base_rx = rx_q.size();
    for (int i = 0; i < 40; i++) begin
      for (int w = 0; w < 200 && m_q.size() >= DEPTH; w++) tick();
      d = 8'($urandom);
      sent.push_back(d);
      wr(d);
      repeat ($urandom_range(0, 6)) tick();
    end
    wait_idle("t4_drain", 5000);
    check_value("t4_rx_len", rx_q.size() - base_rx, 40);
    ok = 1;
    for (int i = 0; i < 40 && base_rx + i < rx_q.size(); i++)
      if (rx_q[base_rx + i] !== sent[i]) ok = 0;
    check_value("t4_rx_order", ok, 1);

    // 5: flush while a frame is on the wire
    base_done = done_cnt;
    for (int i = 0; i < 5; i++) wr(8'h30 + 8'(i));
    for (int i = 0; i < 300 && !(m_cur && m_seen); i++) tick();
    check_value("t5_reach_busy", (m_cur && m_seen), 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_value("t5_count", count, 0);
    wait_idle("t5_drain", 300);
    repeat (20) tick();
    check_value("t5_frames", done_cnt - base_done, 1);

    // 6: reset during REQ with three words queued
    raise_dly = 8;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1;
      wr_data = 8'hC0 + 8'(i);
      tick();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 20 && !(m_cur && !m_seen && m_q.size() == 3); i++) tick();
    check_value("t6_in_req", (m_cur && !m_seen && m_q.size() == 3), 1);
    base_done = done_cnt;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_value("t6_tx_en", tx_en, 0);
    check_value("t6_count", count, 0);
    check_value("t6_empty", empty, 1);
    repeat (15) tick();
    check_value("t6_frames", done_cnt - base_done, 0);
    raise_dly = 3;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
